// File: rtl/seven_segment_arbiter.sv
// -----------------------------------------------------------------------------
// seven_segment_arbiter
//
// Shares a two-digit seven-segment display between two byte producers.
// A grant latches the winner's byte onto the display for HOLD_CYCLES cycles,
// then the winner gets a one-cycle acknowledge. Ties go to the requester that
// did not win last time, so two persistent requesters alternate.
//
// Parameters
//   HOLD_CYCLES  cycles a granted byte is held (1 .. 2**COUNT_WIDTH)
//   COUNT_WIDTH  width of the hold counter
//
// Ports
//   i_Clk      system clock
//   i_Rst      synchronous, active-high reset
//   i_Req_0/1  level requests, held until the matching ack
//   i_Byte_0/1 request bytes, [0:3] = high nibble (left digit)
//   o_Ack_0/1  one-cycle pulse when that requester's hold period ends
//   o_Byte     byte to the display decoder, [0:3] digit 1, [4:7] digit 2
//   o_Blank    high until the first grant after reset
//   o_Owner    index of the current or most recent grantee
//   o_Busy     high while holding or acknowledging
// -----------------------------------------------------------------------------
module seven_segment_arbiter #(
    parameter int unsigned HOLD_CYCLES = 25000000,
    parameter int unsigned COUNT_WIDTH = 25
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Req_0,
    input  logic [0:7] i_Byte_0,
    output logic       o_Ack_0,
    input  logic       i_Req_1,
    input  logic [0:7] i_Byte_1,
    output logic       o_Ack_1,
    output logic [0:7] o_Byte,
    output logic       o_Blank,
    output logic       o_Owner,
    output logic       o_Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Counter value on the last HOLD cycle.
    localparam logic [COUNT_WIDTH-1:0] HOLD_LAST = COUNT_WIDTH'(HOLD_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [0:7]             byte_q, byte_d;
    logic                   blank_q, blank_d;
    logic                   owner_q, owner_d;
    logic                   last_owner_q, last_owner_d;
    logic                   ack_0_q, ack_0_d;
    logic                   ack_1_q, ack_1_d;
    logic                   busy_q, busy_d;
    logic                   grant_1;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        byte_d       = byte_q;
        blank_d      = blank_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        ack_0_d      = 1'b0;
        ack_1_d      = 1'b0;
        grant_1      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_Req_0 || i_Req_1) begin
                    // Requester 1 wins when alone, or on a tie when 0 won last.
                    grant_1      = i_Req_1 && (!i_Req_0 || !last_owner_q);
                    byte_d       = grant_1 ? i_Byte_1 : i_Byte_0;
                    owner_d      = grant_1;
                    last_owner_d = grant_1;
                    blank_d      = 1'b0;
                    count_d      = '0;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (count_q == HOLD_LAST) begin
                    // Ack is registered, so it is raised on the edge entering ACK.
                    state_d = ACK;
                    ack_0_d = !owner_q;
                    ack_1_d = owner_q;
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            byte_q       <= 8'h00;
            blank_q      <= 1'b1;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;   // requester 0 wins the first tie
            ack_0_q      <= 1'b0;
            ack_1_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            byte_q       <= byte_d;
            blank_q      <= blank_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            ack_0_q      <= ack_0_d;
            ack_1_q      <= ack_1_d;
            busy_q       <= busy_d;
        end
    end

    assign o_Ack_0 = ack_0_q;
    assign o_Ack_1 = ack_1_q;
    assign o_Byte  = byte_q;
    assign o_Blank = blank_q;
    assign o_Owner = owner_q;
    assign o_Busy  = busy_q;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_arbiter
//
// Directed bench for seven_segment_arbiter with HOLD_CYCLES=4, COUNT_WIDTH=3.
// Inputs change 1 ns after a rising edge and outputs are observed at the same
// point, so each observation reflects the registers of the current cycle.
// Observed word layout: {ack0, ack1, busy, blank, owner, byte[0:7]}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seven_segment_arbiter;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Req_0 = 1'b0;
    logic [0:7] i_Byte_0 = 8'h00;
    logic       i_Req_1 = 1'b0;
    logic [0:7] i_Byte_1 = 8'h00;
    logic       o_Ack_0, o_Ack_1, o_Blank, o_Owner, o_Busy;
    logic [0:7] o_Byte;

    int vectors = 0;
    int miscompares = 0;

    seven_segment_arbiter #(
        .HOLD_CYCLES(4),
        .COUNT_WIDTH(3)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Req_0 (i_Req_0),
        .i_Byte_0(i_Byte_0),
        .o_Ack_0 (o_Ack_0),
        .i_Req_1 (i_Req_1),
        .i_Byte_1(i_Byte_1),
        .o_Ack_1 (o_Ack_1),
        .o_Byte  (o_Byte),
        .o_Blank (o_Blank),
        .o_Owner (o_Owner),
        .o_Busy  (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        i_Req_0 = 1'b0;
        i_Req_1 = 1'b0;
        tick();
        tick();
        i_Rst = 1'b0;
    endtask

    // Reset, then 10 idle cycles: display blank, byte 00, nothing busy.
    task automatic test_reset();
        logic [12:0] obs, exp;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            obs = {o_Ack_0, o_Ack_1, o_Busy, o_Blank, o_Owner, o_Byte};
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_idle c=%0d got=%h exp=%h", c, obs, exp);
            end
            tick();
        end
    endtask

    // Req 0 with 3A at cycle T: held T+1..T+4, ack at T+5, idle at T+6 on.
    task automatic test_single_request();
        logic [12:0] obs, exp;
        i_Byte_0 = 8'h3A;
        i_Req_0  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) i_Req_0 = 1'b0;
            obs = {o_Ack_0, o_Ack_1, o_Busy, o_Blank, o_Owner, o_Byte};
            exp = {(k == 5), 1'b0, (k <= 5), 1'b0, 1'b0, 8'h3A};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single_req T+%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    // Both high from reset: 11 first (req 0 wins first tie), then 22.
    task automatic test_simultaneous();
        logic [12:0] obs, exp;
        i_Rst = 1'b1;
        i_Byte_0 = 8'h11;
        i_Byte_1 = 8'h22;
        i_Req_0 = 1'b1;
        i_Req_1 = 1'b1;
        tick();
        tick();
        i_Rst = 1'b0;      // cycle T: both requests visible in IDLE
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 6)  i_Req_0 = 1'b0;
            if (k == 12) i_Req_1 = 1'b0;
            if (k <= 6)
                exp = {(k == 5), 1'b0, (k <= 5), 1'b0, 1'b0, 8'h11};
            else
                exp = {1'b0, (k == 11), (k <= 11), 1'b0, 1'b1, 8'h22};
            obs = {o_Ack_0, o_Ack_1, o_Busy, o_Blank, o_Owner, o_Byte};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL simultaneous T+%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    // Both held high forever: grants alternate 0,1,0,1 with a 6-cycle period.
    task automatic test_fairness();
        logic [12:0] obs, exp;
        int g, p;
        logic own;
        do_reset();
        i_Byte_0 = 8'h11;
        i_Byte_1 = 8'h22;
        i_Req_0 = 1'b1;
        i_Req_1 = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            g   = (c - 1) / 6;
            p   = (c - 1) % 6;
            own = g[0];
            exp = {(p == 4) && !own, (p == 4) && own, (p < 5), 1'b0, own,
                   own ? 8'h22 : 8'h11};
            obs = {o_Ack_0, o_Ack_1, o_Busy, o_Blank, o_Owner, o_Byte};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL fairness c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
        i_Req_0 = 1'b0;
        i_Req_1 = 1'b0;
    endtask

    // Byte change and request drop at T+2 must not disturb the hold.
    task automatic test_change_during_hold();
        logic [12:0] obs, exp;
        do_reset();
        i_Byte_0 = 8'h3A;
        i_Req_0  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) begin
                i_Byte_0 = 8'hFF;
                i_Req_0  = 1'b0;
            end
            exp = {(k == 5), 1'b0, (k <= 5), 1'b0, 1'b0, 8'h3A};
            obs = {o_Ack_0, o_Ack_1, o_Busy, o_Blank, o_Owner, o_Byte};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL hold_change T+%0d got=%h exp=%h", k, obs, exp);
            end
        end
    endtask

    // Reset at T+2 aborts the hold: blank again, no ack, tie priority restored.
    task automatic test_reset_mid_hold();
        logic [12:0] obs, exp;
        do_reset();
        i_Byte_0 = 8'h3A;
        i_Byte_1 = 8'h22;
        i_Req_0  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) i_Rst = 1'b1;
            if (k == 3) begin
                i_Rst   = 1'b0;
                i_Req_0 = 1'b0;
            end
            if (k <= 2)
                exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3A};
            else
                exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
            obs = {o_Ack_0, o_Ack_1, o_Busy, o_Blank, o_Owner, o_Byte};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_mid_hold T+%0d got=%h exp=%h", k, obs, exp);
            end
        end
        // A tie right after reset goes to requester 0 again.
        i_Byte_0 = 8'h11;
        i_Req_0  = 1'b1;
        i_Req_1  = 1'b1;
        tick();
        exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        obs = {o_Ack_0, o_Ack_1, o_Busy, o_Blank, o_Owner, o_Byte};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL tie_after_reset got=%h exp=%h", obs, exp);
        end
        i_Req_0 = 1'b0;
        i_Req_1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_simultaneous();
        test_fairness();
        test_change_during_hold();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Shares the board's two-digit seven-segment display between two independent byte producers, e.g. a hex counter and a UART receive path. Each producer raises a request with a byte; the arbiter grants round-robin, latches the winner's byte onto the display for a fixed hold time, then acknowledges. It sits directly upstream of the byte-to-two-digit seven-segment decoder and drives that decoder's byte input.

## Interface
- HOLD_CYCLES, 25000000: cycles a granted byte stays on the display (1 s at 25 MHz); legal range 1 .. 2^COUNT_WIDTH.
- COUNT_WIDTH, 25: hold-counter width.

- i_Clk  input  1  system clock; sole clock.
- i_Rst  input  1  synchronous, active-high reset.
- i_Req_0  input  1  requester 0 display request; level, held until o_Ack_0.
- i_Byte_0  input  [0:7]  requester 0 byte; [0:3] is the high nibble (left digit).
- o_Ack_0  output  1  one-cycle pulse: requester 0's hold period finished.
- i_Req_1  input  1  requester 1 display request.
- i_Byte_1  input  [0:7]  requester 1 byte.
- o_Ack_1  output  1  one-cycle pulse for requester 1.
- o_Byte  output  [0:7]  byte to the display decoder; [0:3] to digit 1, [4:7] to digit 2.
- o_Blank  output  1  high until the first grant after reset; downstream forces all segments off.
- o_Owner  output  1  index of the current or most recent grantee.
- o_Busy  output  1  high in HOLD and ACK.

## Operation
- States: IDLE, HOLD, ACK.
- IDLE: if neither request is high, stay. If exactly one is high, grant it. If both are high, grant the requester that is not `last_owner`.
  - On a grant, in the same edge: latch that requester's byte into o_Byte, set o_Owner and `last_owner`, clear o_Blank, clear the counter, and go to HOLD.
- HOLD: the counter increments each cycle.
  - When counter = HOLD_CYCLES-1, go to ACK.
  - Requests and bytes are ignored during HOLD; a request dropped mid-hold does not abort the hold.
  - A byte change during HOLD does not alter o_Byte.
- ACK: assert o_Ack_<owner> for exactly one cycle, then go to IDLE.
- Requester rule: deassert the request on the cycle after the ack.
  - A request still high in IDLE is treated as a new request.
  - Round-robin still lets the other requester win any tie.
- o_Byte holds its last value indefinitely in IDLE; the display never goes blank after the first grant.
- Counter is unsigned COUNT_WIDTH bits. It never wraps, because it is cleared on grant and leaves HOLD at HOLD_CYCLES-1.
- Reset values:
  - state IDLE
  - o_Byte 8'h00
  - o_Blank 1
  - o_Ack_0 and o_Ack_1: 0
  - o_Owner 0
  - o_Busy 0
  - counter 0
  - `last_owner` 1, so requester 0 wins the first tie.
- Reset mid-operation: all registers return to reset values on that edge. No ack is issued for the aborted hold, and the display blanks again.

## Timing
- Grant decided on the edge ending IDLE cycle T. Cycle T+1 is the first HOLD cycle, with o_Byte, o_Owner, o_Busy=1 and o_Blank=0 all valid.
- HOLD lasts exactly HOLD_CYCLES cycles (T+1 .. T+HOLD_CYCLES).
- ACK occupies cycle T+HOLD_CYCLES+1, with o_Ack high and o_Busy high.
- IDLE resumes at T+HOLD_CYCLES+2. The earliest next grant takes effect at T+HOLD_CYCLES+3.
- Request-to-display latency: 1 cycle from a request seen in IDLE.
- Acks: all outputs are registered. o_Ack_0 and o_Ack_1 are never high together.

## Test plan
All scenarios use HOLD_CYCLES=4 and COUNT_WIDTH=3.
- Reset then idle: 10 cycles, no requests -> o_Blank=1, o_Byte=8'h00, o_Busy=0, no acks.
- Single request: i_Req_0=1, i_Byte_0=8'h3A at cycle T.
  - o_Byte=8'h3A, o_Blank=0 and o_Owner=0 at T+1.
  - o_Ack_0 high only at T+5; o_Busy high T+1..T+5.
- Simultaneous requests: both high from reset, bytes 8'h11 and 8'h22, each dropped the cycle after its ack.
  - Req 0 is granted first: o_Byte=8'h11.
  - Then 8'h22 from T+7, with o_Owner=1 and o_Ack_1 at T+11.
- Fairness under persistent requests: both held high continuously -> grants alternate 0,1,0,1; each ack is one cycle.
- Input change and drop during HOLD: i_Byte_0 changes to 8'hFF and i_Req_0 drops at T+2 -> o_Byte stays 8'h3A and o_Ack_0 still fires at T+5.
- Reset mid-hold: i_Rst high at T+2 -> at T+3 o_Blank=1, o_Byte=8'h00, o_Busy=0; no ack at T+5.
